// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_e;

  localparam logic I2S_LEFT    = 1'b0;
  localparam logic I2S_RIGHT   = 1'b1;
  localparam int   I2S_MIN_OVS = 8;

endpackage

// File: rtl/i2s_rx_sync.sv
// Multi-bit input synchronizer with rising/falling edge detection on bit 0.
module i2s_rx_sync #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_rise,
  output logic         o_fall
);

  logic [W-1:0] r_sync [STAGES];
  logic         r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[STAGES-1][0];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q[0] & ~r_prev;
  assign o_fall = ~o_q[0] & r_prev;

endmodule

// File: rtl/i2s_rx.sv
// Oversampling Philips-format I2S receiver delivering L/R pairs over valid/ready.
// Define I2S_RX_FRAME_CHECK_EN to build slot-length checking (frame_err).
//   state    | meaning
//   ST_IDLE  | waiting for a right->left word-select transition
//   ST_LEFT  | collecting left slot bits
//   ST_RIGHT | collecting right slot bits, pair emitted at slot end
module i2s_rx import i2s_pkg::*; #(
  parameter int SAMPLE_W    = 24,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                i2s_sclk_i,
  input  logic                i2s_lrclk_i,
  input  logic                i2s_sdata_i,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                frame_err
);

  logic [2:0]          w_sync;
  logic                w_rise;
  logic                w_sclk_fall;
  logic                w_lr;
  logic                w_sd;
  logic                w_unused;

  i2s_state_e          r_state;
  i2s_state_e          w_state_nxt;
  logic                w_left_done;
  logic                w_right_done;
  logic                w_slot_end;

  logic                r_lr_d;
  logic [CNT_W-1:0]    r_bitcnt;
  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] r_left;
  logic [SAMPLE_W-1:0] w_bit_vec;
  logic [SAMPLE_W-1:0] w_slot_data;
  logic [SAMPLE_W-1:0] r_sample_l;
  logic [SAMPLE_W-1:0] r_sample_r;
  logic                r_valid;
  logic                r_overrun;

  i2s_rx_sync #(.STAGES(SYNC_STAGES), .W(3)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    ({i2s_sdata_i, i2s_lrclk_i, i2s_sclk_i}),
    .o_q    (w_sync),
    .o_rise (w_rise),
    .o_fall (w_sclk_fall)
  );

  assign w_lr     = w_sync[1];
  assign w_sd     = w_sync[2];
  assign w_unused = &{1'b0, w_sclk_fall, w_sync[0]};

  // Bits at or beyond SAMPLE_W shift out to zero, giving truncation for free.
  assign w_bit_vec   = {w_sd, {(SAMPLE_W-1){1'b0}}} >> r_bitcnt;
  assign w_slot_data = r_shift | w_bit_vec;
  assign w_slot_end  = w_left_done | w_right_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_left_done  = 1'b0;
    w_right_done = 1'b0;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else if (w_rise) begin
      unique case (r_state)
        ST_IDLE:
          if (r_lr_d == I2S_RIGHT && w_lr == I2S_LEFT) w_state_nxt = ST_LEFT;
        ST_LEFT:
          if (w_lr != r_lr_d) begin
            w_left_done = 1'b1;
            w_state_nxt = ST_RIGHT;
          end
        ST_RIGHT:
          if (w_lr != r_lr_d) begin
            w_right_done = 1'b1;
            w_state_nxt  = ST_LEFT;
          end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lr_d     <= 1'b0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_left     <= '0;
      r_sample_l <= '0;
      r_sample_r <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_rise) r_lr_d <= w_lr;
      if (r_valid && sample_ready) r_valid <= 1'b0;
      if (!en || r_state == ST_IDLE) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
      end else if (w_rise) begin
        if (w_slot_end) begin
          r_bitcnt <= '0;
          r_shift  <= '0;
        end else begin
          r_shift <= w_slot_data;
          if (r_bitcnt != '1) r_bitcnt <= r_bitcnt + 1'b1;
        end
        if (w_left_done) r_left <= w_slot_data;
        // A load in the accept cycle overrides the valid clear above.
        if (w_right_done) begin
          if (!r_valid || sample_ready) begin
            r_sample_l <= r_left;
            r_sample_r <= w_slot_data;
            r_valid    <= 1'b1;
          end else begin
            r_overrun  <= 1'b1;
          end
        end
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  logic [CNT_W-1:0] r_left_len;
  logic [CNT_W-1:0] w_len;
  logic             w_short;
  logic             r_frame_err;

  assign w_len   = (r_bitcnt == '1) ? r_bitcnt : r_bitcnt + 1'b1;
  assign w_short = (int'(w_len) < SAMPLE_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_left_len  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_left_done) begin
        r_left_len  <= w_len;
        r_frame_err <= w_short;
      end
      if (w_right_done) r_frame_err <= w_short || (w_len != r_left_len);
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

  assign sample_l     = r_sample_l;
  assign sample_r     = r_sample_r;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

endmodule
